booth4_multiplier: RTL and testbench

Parametrised sequential radix-4 (modified Booth) multiplier that retires two multiplier bits per clock and supports both signed and unsigned operands, selected per operation. It is the successor to the team's one-bit-per-cycle shift-add multiplier. It adds an asynchronous active-low reset, a per-operation signedness mode, a registered result that holds until the next completion, and an explicit ready/busy/done handshake. It sits as a multi-cycle arithmetic unit behind a datapath controller that issues `start` and consumes `Product` on `done`.

---
 rtl/booth4_multiplier.sv | 127 ++++++++++++
 tb/tb_booth4_multiplier.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/booth4_multiplier.sv
// Sequential radix-4 (modified Booth) multiplier.
// Retires two multiplier bits per clock. Signed or unsigned operands are
// selected per operation. The result register holds until the next completion.
module booth4_multiplier #(
    parameter int unsigned nb = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            is_signed,
    input  logic [nb-1:0]   A,
    input  logic [nb-1:0]   B,
    output logic [2*nb-1:0] Product,
    output logic            ready,
    output logic            busy,
    output logic            done
);

    localparam int unsigned Iter = nb / 2 + 1;
    localparam int unsigned CntW = $clog2(Iter) + 1;
    localparam int unsigned ExtW = nb + 2;
    localparam int unsigned AccW = nb + 3;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ExtW-1:0]   m_q, m_d;
    logic [AccW-1:0]   acc_q, acc_d;
    logic [ExtW-1:0]   q_q, q_d;
    logic              q1_q, q1_d;
    logic [2*nb-1:0]   product_q, product_d;
    logic              done_q, done_d;

    logic [ExtW-1:0]   a_ext, b_ext;
    logic [AccW-1:0]   m_x1, m_x2, term, sum;

    // Widen operands by two bits so full-range unsigned values recode correctly.
    always_comb begin
        a_ext = is_signed ? {{2{A[nb-1]}}, A} : {2'b00, A};
        b_ext = is_signed ? {{2{B[nb-1]}}, B} : {2'b00, B};
    end

    // Booth recoding of {q[1], q[0], q_1} into the partial-product term.
    always_comb begin
        m_x1 = {m_q[ExtW-1], m_q};
        m_x2 = {m_q, 1'b0};
        term = '0;
        unique case ({q_q[1:0], q1_q})
            3'b001, 3'b010: term = m_x1;
            3'b011:         term = m_x2;
            3'b100:         term = -m_x2;
            3'b101, 3'b110: term = -m_x1;
            default:        term = '0;
        endcase
        sum = acc_q + term;
    end

    // Next-state logic: load on accept, add-and-shift while running.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        m_d       = m_q;
        acc_d     = acc_q;
        q_d       = q_q;
        q1_d      = q1_q;
        product_d = product_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    m_d     = a_ext;
                    q_d     = b_ext;
                    acc_d   = '0;
                    q1_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                // Arithmetic shift of {sum, q, q_1} right by two.
                acc_d = {{2{sum[AccW-1]}}, sum[AccW-1:2]};
                q_d   = {sum[1:0], q_q[ExtW-1:2]};
                q1_d  = q_q[1];
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(Iter - 1)) begin
                    product_d = {acc_d[nb-3:0], q_d};
                    done_d    = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            m_q       <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            q1_q      <= 1'b0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            q1_q      <= q1_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    // Handshake decoded from the state register only.
    always_comb begin
        ready   = (state_q == StIdle);
        busy    = ~ready;
        Product = product_q;
        done    = done_q;
    end

endmodule

// File: tb/tb_booth4_multiplier.sv
// Self-checking bench: directed nb=8 cases plus random nb=32 cases against a
// plain-arithmetic reference product.
module tb_booth4_multiplier;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        s8_start = 1'b0, s8_sgn = 1'b0;
    logic [7:0]  s8_a = '0, s8_b = '0;
    logic [15:0] s8_prod;
    logic        s8_ready, s8_busy, s8_done;

    logic        s32_start = 1'b0, s32_sgn = 1'b0;
    logic [31:0] s32_a = '0, s32_b = '0;
    logic [63:0] s32_prod;
    logic        s32_ready, s32_busy, s32_done;

    int n_checks = 0;
    int n_pass = 0;
    int dones8 = 0, dones32 = 0, starts32 = 0;

    localparam int N32 = 600;

    booth4_multiplier #(.nb(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(s8_start), .is_signed(s8_sgn),
        .A(s8_a), .B(s8_b), .Product(s8_prod), .ready(s8_ready),
        .busy(s8_busy), .done(s8_done)
    );

    booth4_multiplier #(.nb(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(s32_start), .is_signed(s32_sgn),
        .A(s32_a), .B(s32_b), .Product(s32_prod), .ready(s32_ready),
        .busy(s32_busy), .done(s32_done)
    );

    always #5 clk = ~clk;

    // Count done pulses away from the active edge.
    always @(negedge clk) begin
        if (s8_done) dones8++;
        if (s32_done) dones32++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ref_mul32(input logic sgn, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb;
        if (sgn) begin
            sa = longint'(int'(a));
            sb = longint'(int'(b));
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    task automatic run8(input string tag, input logic sgn, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] exp);
        int cyc;
        check({tag, "_ready"}, 64'(s8_ready), 64'd1);
        s8_sgn = sgn; s8_a = a; s8_b = b; s8_start = 1'b1;
        tick();
        s8_start = 1'b0;
        s8_a = 8'($urandom); s8_b = 8'($urandom); s8_sgn = ~sgn;
        check({tag, "_busy"}, 64'(s8_busy), 64'd1);
        cyc = 0;
        while (!s8_done && cyc < 20) begin tick(); cyc++; end
        check({tag, "_lat"}, 64'(cyc), 64'd5);
        check({tag, "_prod"}, 64'(s8_prod), 64'(exp));
        tick();
        check({tag, "_done_low"}, 64'(s8_done), 64'd0);
        check({tag, "_hold"}, 64'(s8_prod), 64'(exp));
    endtask

    task automatic run32(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        int cyc;
        logic [63:0] exp;
        exp = ref_mul32(sgn, a, b);
        s32_sgn = sgn; s32_a = a; s32_b = b; s32_start = 1'b1;
        tick();
        starts32++;
        s32_start = 1'b0;
        s32_a = $urandom; s32_b = $urandom;
        cyc = 0;
        while (!s32_done && cyc < 40) begin tick(); cyc++; end
        check(sgn ? "s32_lat" : "u32_lat", 64'(cyc), 64'd17);
        check(sgn ? "s32_prod" : "u32_prod", s32_prod, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, base;
        logic [31:0] corner [4];
        corner[0] = 32'h8000_0000; corner[1] = 32'hFFFF_FFFF;
        corner[2] = 32'h7FFF_FFFF; corner[3] = 32'h0000_0000;

        #3;
        check("rst_prod8", 64'(s8_prod), 64'd0);
        check("rst_done8", 64'(s8_done), 64'd0);
        check("rst_ready8", 64'(s8_ready), 64'd1);
        check("rst_busy8", 64'(s8_busy), 64'd0);
        check("rst_prod32", s32_prod, 64'd0);
        check("rst_ready32", 64'(s32_ready), 64'd1);
        tick();
        rst_n = 1'b1;
        tick();

        // Directed nb=8 cases.
        run8("u_ff_ff", 1'b0, 8'd255, 8'd255, 16'hFE01);
        run8("s_m128_m128", 1'b1, 8'h80, 8'h80, 16'h4000);
        run8("s_m1_1", 1'b1, 8'hFF, 8'h01, 16'hFFFF);
        run8("s_127_m128", 1'b1, 8'h7F, 8'h80, 16'hC080);

        // Start while busy is ignored.
        base = dones8;
        s8_sgn = 1'b0; s8_a = 8'd3; s8_b = 8'd5; s8_start = 1'b1;
        tick();
        s8_start = 1'b0;
        cyc = 0;
        while (!s8_done && cyc < 20) begin
            if (cyc == 1) begin s8_start = 1'b1; s8_a = 8'd7; s8_b = 8'd7; end
            else s8_start = 1'b0;
            tick();
            cyc++;
        end
        s8_start = 1'b0;
        check("busy_lat", 64'(cyc), 64'd5);
        check("busy_prod", 64'(s8_prod), 64'd15);

        // Back-to-back start in the done cycle.
        s8_a = 8'd2; s8_b = 8'd9; s8_start = 1'b1;
        tick();
        s8_start = 1'b0;
        cyc = 0;
        while (!s8_done && cyc < 20) begin
            check("b2b_hold", 64'(s8_prod), 64'd15);
            tick();
            cyc++;
        end
        check("b2b_lat", 64'(cyc), 64'd5);
        check("b2b_prod", 64'(s8_prod), 64'd18);
        repeat (8) tick();
        check("b2b_dones", 64'(dones8 - base), 64'd2);
        check("b2b_idle", 64'(s8_ready), 64'd1);

        // Reset mid-operation aborts with no done pulse.
        base = dones8;
        s8_a = 8'd11; s8_b = 8'd13; s8_start = 1'b1;
        tick();
        s8_start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_prod", 64'(s8_prod), 64'd0);
        check("mid_rst_done", 64'(s8_done), 64'd0);
        check("mid_rst_ready", 64'(s8_ready), 64'd1);
        check("mid_rst_busy", 64'(s8_busy), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (8) tick();
        check("mid_rst_nodone", 64'(dones8 - base), 64'd0);
        check("mid_rst_prod_hold", 64'(s8_prod), 64'd0);
        run8("post_rst_6x7", 1'b0, 8'd6, 8'd7, 16'd42);

        // nb=32: corner pairs then random operands, both modes.
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 16; i++) run32(m[0], corner[i % 4], corner[i / 4]);
            for (int i = 0; i < N32; i++) run32(m[0], $urandom, $urandom);
        end
        repeat (20) tick();
        check("dones32", 64'(dones32), 64'(starts32));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
